// File: rtl/dpseq_pkg.sv
// Shared definitions for the datapath sequencer: instruction field layout,
// class encodings and FSM state type.
package dpseq_pkg;

  localparam int INSTR_W = 16;

  localparam int CLS_MSB = 15;
  localparam int CLS_LSB = 13;
  localparam int WR_MSB  = 12;
  localparam int WR_LSB  = 10;
  localparam int RDA_MSB = 9;
  localparam int RDA_LSB = 7;
  localparam int RDB_MSB = 6;
  localparam int RDB_LSB = 4;
  localparam int S_MSB   = 3;
  localparam int S_LSB   = 2;
  localparam int OPC_BIT = 1;

  localparam logic [2:0] CLS_NOP    = 3'b000;
  localparam logic [2:0] CLS_LOAD   = 3'b001;
  localparam logic [2:0] CLS_ALU    = 3'b010;
  localparam logic [2:0] CLS_OUT    = 3'b011;
  localparam logic [2:0] CLS_ALUOUT = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_DONE,
    ST_TRAP
  } state_e;

endpackage

// File: rtl/dpseq_decode.sv
// Combinational class decoder: instruction class -> datapath enables.
// Illegal classes produce no enables and raise the illegal flag.
module dpseq_decode
  import dpseq_pkg::*;
(
  input  logic [2:0] cls,
  output logic       ie,
  output logic       we,
  output logic       oe,
  output logic       illegal
);

  always_comb begin
    ie      = 1'b0;
    we      = 1'b0;
    oe      = 1'b0;
    illegal = 1'b0;
    case (cls)
      CLS_NOP:    ;
      CLS_LOAD:   begin ie = 1'b1; we = 1'b1; end
      CLS_ALU:    we = 1'b1;
      CLS_OUT:    oe = 1'b1;
      CLS_ALUOUT: begin we = 1'b1; oe = 1'b1; end
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Four-cycle instruction sequencer (IDLE->DECODE->EXEC->DONE) driving the
// datapath control pins. Define DPSEQ_ILLEGAL_TRAP_EN to trap illegal classes.
module datapath_sequencer
  import dpseq_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               err_clr,
  output logic               IE,
  output logic               WE,
  output logic               OE,
  output logic [1:0]         S,
  output logic [2:0]         ADDR_WR,
  output logic [2:0]         ADDR_RDA,
  output logic [2:0]         ADDR_RDB,
  output logic               Opcode,
  output logic               done,
  output logic               busy,
  output logic               err
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               err_q, err_d;

  logic dec_ie, dec_we, dec_oe, dec_illegal;
  logic in_exec;

  dpseq_decode u_decode (
    .cls     (ir_q[CLS_MSB:CLS_LSB]),
    .ie      (dec_ie),
    .we      (dec_we),
    .oe      (dec_oe),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
`ifdef DPSEQ_ILLEGAL_TRAP_EN
      ST_EXEC:   state_d = dec_illegal ? ST_TRAP : ST_DONE;
      ST_TRAP:   if (err_clr) state_d = ST_IDLE;
`else
      ST_EXEC:   state_d = ST_DONE;
`endif
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

`ifdef DPSEQ_ILLEGAL_TRAP_EN
    // Setting on an illegal EXEC takes priority over a simultaneous clear.
    if (state_q == ST_EXEC && dec_illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // Outputs depend only on registered state and IR.
  assign in_exec     = (state_q == ST_EXEC);
  assign IE          = in_exec & dec_ie;
  assign WE          = in_exec & dec_we;
  assign OE          = in_exec & dec_oe;
  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;

  assign S        = ir_q[S_MSB:S_LSB];
  assign ADDR_WR  = ir_q[WR_MSB:WR_LSB];
  assign ADDR_RDA = ir_q[RDA_MSB:RDA_LSB];
  assign ADDR_RDB = ir_q[RDB_MSB:RDB_LSB];
  assign Opcode   = ir_q[OPC_BIT];

  // IR bit 0 is reserved; the trap-related inputs only matter with the trap build.
  logic unused_bits;
`ifdef DPSEQ_ILLEGAL_TRAP_EN
  assign unused_bits = ir_q[0];
`else
  assign unused_bits = ^{ir_q[0], err_clr, dec_illegal};
`endif

endmodule
